tour_cmd_gen: RTL and testbench
===============================

TOUR_CMD_GEN -- requirements
Module: tour_cmd_gen

Interface
REQ-001 The module SHALL use one clock and an asynchronous active-low reset: clk input 1 (system clock, rising edge); rst_n input 1 (asynchronous reset, active low).
REQ-002 cmd_UART input 16: command from the UART wrapper.
REQ-003 cmd_rdy_UART input 1: cmd_UART is valid.
REQ-004 tour_go input 1: single-cycle pulse that starts a 24-move tour.
REQ-005 move input 8: one-hot knight move, read combinationally from the move store at mv_indx.
REQ-006 clr_cmd_rdy input 1: the command processor has consumed cmd.
REQ-007 send_resp input 1: the command processor has finished the command.
REQ-008 cmd output 16 and cmd_rdy output 1: command and valid flag to the command processor.
REQ-009 clr_cmd_rdy_UART output 1: consume acknowledge to the UART wrapper.
REQ-010 mv_indx output 5: current tour move index, 0..23.
REQ-011 resp output 8: response byte that accompanies send_resp.

Function
REQ-012 The state machine SHALL have the states IDLE, VERT, VERT_WAIT, HORZ and HORZ_WAIT.
REQ-013 In IDLE the module SHALL pass the UART interface straight through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
REQ-014 A tour_go pulse in IDLE SHALL clear mv_indx to 0 and move to VERT on the next clock.
REQ-015 A tour_go pulse in any other state SHALL be ignored.
REQ-016 In every non-IDLE state, cmd SHALL be the decoded tour command and clr_cmd_rdy_UART SHALL be 0.
REQ-017 VERT: cmd_rdy=1, cmd=vertical leg with opcode 4'b0100; on clr_cmd_rdy the machine SHALL deassert cmd_rdy and go to VERT_WAIT.
REQ-018 VERT_WAIT: cmd_rdy=0 and cmd held; on send_resp the machine SHALL go to HORZ.
REQ-019 HORZ: cmd_rdy=1, cmd=horizontal leg with opcode 4'b0101 (move with fanfare); on clr_cmd_rdy the machine SHALL go to HORZ_WAIT.
REQ-020 HORZ_WAIT: on send_resp with mv_indx==23 the machine SHALL go to IDLE; on send_resp otherwise it SHALL increment mv_indx and go to VERT.
REQ-021 Command encoding SHALL be cmd[15:12]=opcode, cmd[11:4]=heading, cmd[3]=0, cmd[2:0]=square count.
REQ-022 Headings SHALL be N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
REQ-023 Decode SHALL be: bit0 N2/W1, bit1 N2/E1, bit2 N1/W2, bit3 S1/W2, bit4 S2/W1, bit5 S2/E1, bit6 S1/E2, bit7 N1/E2; the first named step is the vertical leg, the second the horizontal leg.
REQ-024 If move has multiple bits set, the lowest set bit SHALL win; if move is all zero, both legs SHALL have count 0 and heading N.
REQ-025 resp SHALL be 8'hA5 in IDLE and in HORZ_WAIT when mv_indx==23, and 8'h5A otherwise.
REQ-026 clr_cmd_rdy arriving in a WAIT state SHALL be ignored; send_resp arriving in VERT or HORZ SHALL be ignored.
REQ-027 mv_indx SHALL hold its value when the machine returns to IDLE.

Reset
REQ-028 While rst_n is low, the machine SHALL go to IDLE, mv_indx SHALL be 0 and all registered outputs SHALL be 0, immediately and regardless of clk.
REQ-029 A reset during a tour SHALL abandon it; no resumption.

Configuration
REQ-030 With TOUR_ABORT_EN defined, cmd_rdy_UART=1 while in VERT SHALL pulse clr_cmd_rdy_UART for one cycle and return the machine to IDLE without issuing the vertical leg; the UART command SHALL be discarded.
REQ-031 Without TOUR_ABORT_EN, cmd_rdy_UART SHALL be ignored in all non-IDLE states.

Structure
REQ-032 Package tour_cmd_pkg SHALL hold the opcode constants (MOVE=4'b0100, MOVE_FANFARE=4'b0101), the heading constants, the state enum and LAST_MOVE=5'd23.
REQ-033 Sub-module tour_move_decode SHALL be purely combinational, mapping move[7:0] to the vertical and horizontal heading/count pairs.

Verification
REQ-034 tour_go with move=8'h01: first cmd=16'h4002 and cmd_rdy=1; after clr_cmd_rdy then send_resp, cmd=16'h53F1 and cmd_rdy=1.
REQ-035 A 24-move run with a constant send_resp responder: mv_indx counts 0..23, resp=5A on 47 responses and A5 on the last, and the machine ends in IDLE.
REQ-036 In IDLE, cmd_UART=16'h2000 with cmd_rdy_UART=1: cmd=16'h2000 and cmd_rdy=1; clr_cmd_rdy=1 gives clr_cmd_rdy_UART=1.
REQ-037 Reset asserted in HORZ_WAIT at mv_indx=7: immediately IDLE, mv_indx=0, cmd_rdy=0.
REQ-038 move=8'h81 gives the bit0 legs; move=8'h00 gives cmd=16'h4000.
REQ-039 Under TOUR_ABORT_EN, cmd_rdy_UART pulsed in VERT: one clr_cmd_rdy_UART pulse, return to IDLE, no cmd_rdy on the tour leg.

Source files
------------

// File: rtl/tour_cmd_pkg.sv
// Shared constants, state encoding and command packing for the knight-tour command generator.
`timescale 1ns/1ps
package tour_cmd_pkg;

  localparam logic [3:0] MOVE         = 4'b0100;
  localparam logic [3:0] MOVE_FANFARE = 4'b0101;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [4:0] LAST_MOVE = 5'd23;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    VERT_WAIT,
    HORZ,
    HORZ_WAIT
  } state_t;

  typedef struct packed {
    logic [7:0] heading;
    logic [2:0] count;
  } leg_t;

  function automatic logic [15:0] pack_cmd(input logic [3:0] op, input leg_t leg);
    return {op, leg.heading, 1'b0, leg.count};
  endfunction

endpackage

// File: rtl/tour_cmd_gen_if.sv
// Command/response bundle between UART wrapper, tour generator and command processor.
`timescale 1ns/1ps
interface tour_cmd_gen_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic        tour_go;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, tour_go, move, clr_cmd_rdy, send_resp,
    output cmd, cmd_rdy, clr_cmd_rdy_UART, mv_indx, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, tour_go, move, clr_cmd_rdy, send_resp,
    input  cmd, cmd_rdy, clr_cmd_rdy_UART, mv_indx, resp
  );
endinterface

// File: rtl/tour_move_decode.sv
// Combinational split of a one-hot knight move into vertical and horizontal legs.
`timescale 1ns/1ps
module tour_move_decode
  import tour_cmd_pkg::*;
(
  input  logic [7:0] move_i,
  output leg_t       vert_o,
  output leg_t       horz_o
);

  logic [7:0] low_bit;

  // Isolate the lowest set bit so multi-hot moves resolve deterministically.
  assign low_bit = move_i & (~move_i + 8'd1);

  always_comb begin
    vert_o = '{heading: HEAD_N, count: 3'd0};
    horz_o = '{heading: HEAD_N, count: 3'd0};
    case (low_bit)
      8'h01: begin vert_o = '{HEAD_N, 3'd2}; horz_o = '{HEAD_W, 3'd1}; end
      8'h02: begin vert_o = '{HEAD_N, 3'd2}; horz_o = '{HEAD_E, 3'd1}; end
      8'h04: begin vert_o = '{HEAD_N, 3'd1}; horz_o = '{HEAD_W, 3'd2}; end
      8'h08: begin vert_o = '{HEAD_S, 3'd1}; horz_o = '{HEAD_W, 3'd2}; end
      8'h10: begin vert_o = '{HEAD_S, 3'd2}; horz_o = '{HEAD_W, 3'd1}; end
      8'h20: begin vert_o = '{HEAD_S, 3'd2}; horz_o = '{HEAD_E, 3'd1}; end
      8'h40: begin vert_o = '{HEAD_S, 3'd1}; horz_o = '{HEAD_E, 3'd2}; end
      8'h80: begin vert_o = '{HEAD_N, 3'd1}; horz_o = '{HEAD_E, 3'd2}; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tour_cmd_gen.sv
// Knight-tour command generator: muxes UART commands with 24 two-leg tour moves.
// Optional TOUR_ABORT_EN: a UART command arriving in VERT aborts the tour.
`timescale 1ns/1ps
module tour_cmd_gen
  import tour_cmd_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  tour_cmd_gen_if.master bus
);

  state_t     state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;
  leg_t       vert_leg, horz_leg;
  logic       abort;

  tour_move_decode u_decode (
    .move_i (bus.move),
    .vert_o (vert_leg),
    .horz_o (horz_leg)
  );

`ifdef TOUR_ABORT_EN
  assign abort = (state_q == VERT) && bus.cmd_rdy_UART;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    case (state_q)
      IDLE: begin
        if (bus.tour_go) begin
          state_d   = VERT;
          mv_indx_d = '0;
        end
      end
      VERT: begin
        if (abort)                state_d = IDLE;
        else if (bus.clr_cmd_rdy) state_d = VERT_WAIT;
      end
      VERT_WAIT: begin
        if (bus.send_resp) state_d = HORZ;
      end
      HORZ: begin
        if (bus.clr_cmd_rdy) state_d = HORZ_WAIT;
      end
      HORZ_WAIT: begin
        if (bus.send_resp) begin
          if (mv_indx_q == LAST_MOVE) begin
            state_d = IDLE;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd              = pack_cmd(MOVE, vert_leg);
    bus.cmd_rdy          = 1'b0;
    bus.clr_cmd_rdy_UART = 1'b0;
    bus.resp             = RESP_ACK;
    bus.mv_indx          = mv_indx_q;
    case (state_q)
      IDLE: begin
        bus.cmd              = bus.cmd_UART;
        bus.cmd_rdy          = bus.cmd_rdy_UART;
        bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
        bus.resp             = RESP_DONE;
      end
      VERT: begin
        // An abort withholds the vertical leg and acknowledges the UART instead.
        bus.cmd_rdy          = ~abort;
        bus.clr_cmd_rdy_UART = abort;
      end
      VERT_WAIT: ;
      HORZ: begin
        bus.cmd     = pack_cmd(MOVE_FANFARE, horz_leg);
        bus.cmd_rdy = 1'b1;
      end
      HORZ_WAIT: begin
        bus.cmd = pack_cmd(MOVE_FANFARE, horz_leg);
        if (mv_indx_q == LAST_MOVE) bus.resp = RESP_DONE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_gen.sv
// Self-checking bench for tour_cmd_gen: decode table, full tour, pass-through and reset corners.
`timescale 1ns/1ps
module tb_tour_cmd_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tour_cmd_gen_if bus();

  tour_cmd_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [7:0] store [32];
  logic [7:0] move_reg;
  logic       use_store;
  assign bus.move = use_store ? store[bus.mv_indx] : move_reg;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } vec_t;
  vec_t vecs[12];

  int checks = 0;
  int failures = 0;
  int n5a = 0;
  int na5 = 0;
  logic [15:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic collect(input string nm);
    int n;
    logic [15:0] e;
    n = 0;
    #1;
    while (bus.cmd_rdy !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    if (bus.cmd_rdy !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=cmd_rdy_low required=cmd_rdy_high @%0t", nm, $time);
    end else begin
      chk(nm, bus.cmd, e);
    end
  endtask

  task automatic handshake();
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    #1;
    chk("cmd_rdy_after_clr", bus.cmd_rdy, 1'b0);
  endtask

  task automatic respond(input logic [7:0] exp_resp);
    #1;
    chk("resp", bus.resp, exp_resp);
    if (bus.resp === 8'h5A) n5a++;
    if (bus.resp === 8'hA5) na5++;
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
  endtask

  task automatic start_tour();
    bus.tour_go = 1'b1;
    tick();
    bus.tour_go = 1'b0;
  endtask

  task automatic do_move(input int idx, input logic [15:0] ev, input logic [15:0] eh, input bit last);
    exp_q.push_back(ev);
    collect("vert_cmd");
    chk("mv_indx", bus.mv_indx, idx[4:0]);
    handshake();
    respond(8'h5A);
    exp_q.push_back(eh);
    collect("horz_cmd");
    handshake();
    respond(last ? 8'hA5 : 8'h5A);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h01, 16'h4002, 16'h53F1};
    vecs[1]  = '{8'h02, 16'h4002, 16'h5BF1};
    vecs[2]  = '{8'h04, 16'h4001, 16'h53F2};
    vecs[3]  = '{8'h08, 16'h47F1, 16'h53F2};
    vecs[4]  = '{8'h10, 16'h47F2, 16'h53F1};
    vecs[5]  = '{8'h20, 16'h47F2, 16'h5BF1};
    vecs[6]  = '{8'h40, 16'h47F1, 16'h5BF2};
    vecs[7]  = '{8'h80, 16'h4001, 16'h5BF2};
    vecs[8]  = '{8'h81, 16'h4002, 16'h53F1};
    vecs[9]  = '{8'h00, 16'h4000, 16'h5000};
    vecs[10] = '{8'h0C, 16'h4001, 16'h53F2};
    vecs[11] = '{8'hF0, 16'h47F2, 16'h53F1};
    for (int i = 0; i < 32; i++) store[i] = 8'h01 << (i % 8);

    bus.cmd_UART = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.tour_go = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    move_reg = 8'h00;
    use_store = 1'b0;

    // Reset state
    rst_n = 1'b0;
    #1;
    chk("rst_mv_indx", bus.mv_indx, 5'd0);
    chk("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    chk("rst_clr_uart", bus.clr_cmd_rdy_UART, 1'b0);
    chk("rst_resp", bus.resp, 8'hA5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // IDLE pass-through
    bus.cmd_UART = 16'h2000;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("pass_cmd", bus.cmd, 16'h2000);
    chk("pass_cmd_rdy", bus.cmd_rdy, 1'b1);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("pass_clr_uart", bus.clr_cmd_rdy_UART, 1'b1);
    bus.clr_cmd_rdy = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    tick();
    chk("pass_stays_idle", bus.resp, 8'hA5);

    // Decode table: first move of a tour, then the index step into move 1
    for (int i = 0; i < 12; i++) begin
      move_reg = vecs[i].mv;
      start_tour();
      do_move(0, vecs[i].v, vecs[i].h, 1'b0);
      #1;
      chk("mv_indx_step", bus.mv_indx, 5'd1);
      do_reset();
    end

    // Ignored inputs in the non-IDLE states
    move_reg = 8'h01;
    start_tour();
`ifdef TOUR_ABORT_EN
    bus.cmd_UART = 16'h1111;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("abort_clr_uart", bus.clr_cmd_rdy_UART, 1'b1);
    chk("abort_no_cmd_rdy", bus.cmd_rdy, 1'b0);
    tick();
    bus.cmd_rdy_UART = 1'b0;
    #1;
    chk("abort_clr_uart_pulse", bus.clr_cmd_rdy_UART, 1'b0);
    chk("abort_idle_resp", bus.resp, 8'hA5);
    start_tour();
`else
    bus.cmd_rdy_UART = 1'b1;
    bus.cmd_UART = 16'h1111;
    tick();
    bus.cmd_rdy_UART = 1'b0;
    #1;
    chk("uart_ignored_cmd", bus.cmd, 16'h4002);
    chk("uart_ignored_rdy", bus.cmd_rdy, 1'b1);
    chk("uart_ignored_clr", bus.clr_cmd_rdy_UART, 1'b0);
`endif
    exp_q.push_back(16'h4002);
    collect("ign_vert_cmd");
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
    #1;
    chk("send_in_vert_ignored", bus.cmd_rdy, 1'b1);
    bus.tour_go = 1'b1;
    tick();
    bus.tour_go = 1'b0;
    #1;
    chk("go_in_vert_ignored", bus.cmd_rdy, 1'b1);
    handshake();
    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    #1;
    chk("clr_in_wait_ignored", bus.cmd_rdy, 1'b0);
    chk("vert_wait_cmd_held", bus.cmd, 16'h4002);
    respond(8'h5A);
    exp_q.push_back(16'h53F1);
    collect("ign_horz_cmd");
    handshake();
    chk("horz_wait_cmd_held", bus.cmd, 16'h53F1);
    do_reset();

    // Full 24-move tour from the move store
    use_store = 1'b1;
    n5a = 0;
    na5 = 0;
    start_tour();
    for (int i = 0; i < 24; i++) do_move(i, vecs[i % 8].v, vecs[i % 8].h, i == 23);
    bus.cmd_UART = 16'h1234;
    #1;
    chk("tour_end_idle_cmd", bus.cmd, 16'h1234);
    chk("tour_end_resp", bus.resp, 8'hA5);
    chk("tour_end_mv_indx", bus.mv_indx, 5'd23);
    chk("resp_5a_count", n5a, 47);
    chk("resp_a5_count", na5, 1);

    // Reset while in HORZ_WAIT at move 7
    do_reset();
    start_tour();
    for (int i = 0; i < 7; i++) do_move(i, vecs[i].v, vecs[i].h, 1'b0);
    exp_q.push_back(vecs[7].v);
    collect("m7_vert_cmd");
    handshake();
    respond(8'h5A);
    exp_q.push_back(vecs[7].h);
    collect("m7_horz_cmd");
    handshake();
    chk("m7_mv_indx", bus.mv_indx, 5'd7);
    bus.cmd_UART = 16'hBEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mv_indx", bus.mv_indx, 5'd0);
    chk("async_rst_cmd_rdy", bus.cmd_rdy, 1'b0);
    chk("async_rst_idle_cmd", bus.cmd, 16'hBEEF);
    chk("async_rst_resp", bus.resp, 8'hA5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_resume_cmd_rdy", bus.cmd_rdy, 1'b0);
    chk("no_resume_mv_indx", bus.mv_indx, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
